reaction_timer_ctrl: RTL and testbench

//   Sequencer for one reaction-timer trial. Drives the 12-bit random source
//   (enable) and the 12-bit down counter (load/enable/preset). Runs a random
//   pre-delay, asserts the GO indicator, then measures response time in
//   1 ms ticks. Sits between the debounced button logic and the display.

---
 rtl/reaction_timer_ctrl.sv | 110 +++++++++++
 tb/tb_reaction_timer_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_ctrl.sv
// rtl/reaction_timer_ctrl.sv - reaction-timer trial sequencer
module reaction_timer_ctrl #(
  parameter int W          = 12,
  parameter int RW         = 10,
  parameter int MIN_DELAY  = 500,
  parameter int TIMEOUT_MS = 999
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          start,
  input  logic          react,
  input  logic [W-1:0]  rand_in,
  input  logic [W-1:0]  cnt_val,
  output logic          lfsr_en,
  output logic          cnt_load,
  output logic [W-1:0]  cnt_d,
  output logic          cnt_en,
  output logic          led_go,
  output logic          busy,
  output logic [RW-1:0] result,
  output logic          result_valid,
  output logic          early,
  output logic          timeout
);

  localparam logic [W-1:0]  MIN_D = W'(MIN_DELAY);
  localparam logic [RW-1:0] TMO   = RW'(TIMEOUT_MS);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_GO, S_DONE, S_FOUL} state_t;

  state_t        state, state_nx;
  logic [RW-1:0] rt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    lfsr_en  = 1'b0;
    cnt_load = 1'b0;
    cnt_d    = '0;
    cnt_en   = 1'b0;
    led_go   = 1'b0;
    busy     = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_FOUL: begin
        lfsr_en = 1'b1;
        if (start) state_nx = S_ARM;
      end
      S_ARM: begin
        busy     = 1'b1;
        cnt_load = 1'b1;
        cnt_d    = (rand_in < MIN_D) ? MIN_D : rand_in;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        busy   = 1'b1;
        // Gate the decrement at zero so the external counter cannot wrap.
        cnt_en = tick & (cnt_val != '0);
        if (react)               state_nx = S_FOUL;
        else if (cnt_val == '0)  state_nx = S_GO;
      end
      S_GO: begin
        busy   = 1'b1;
        led_go = 1'b1;
        if (react || rt == TMO) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rt           <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      early        <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      case (state)
        S_ARM: begin
          rt           <= '0;
          result_valid <= 1'b0;
          early        <= 1'b0;
          timeout      <= 1'b0;
        end
        S_WAIT: begin
          if (react) early <= 1'b1;
        end
        S_GO: begin
          // A tick coinciding with the press is not counted.
          if (react) begin
            result       <= rt;
            result_valid <= 1'b1;
          end else if (rt == TMO) begin
            result  <= TMO;
            timeout <= 1'b1;
          end else if (tick) begin
            rt <= rt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// tb/tb_reaction_timer_ctrl.sv - directed bench for reaction_timer_ctrl
module tb_reaction_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        react = 1'b0;
  logic [11:0] rand_in = '0;
  logic [11:0] cnt_val;
  logic        lfsr_en, cnt_load, cnt_en, led_go, busy;
  logic [11:0] cnt_d;
  logic [9:0]  result;
  logic        result_valid, early, timeout;

  logic        use_model = 1'b0;
  logic [11:0] cnt_force = '0;
  logic [11:0] cnt_q;

  int vectors = 0;
  int miscompares = 0;

  reaction_timer_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .react(react),
    .rand_in(rand_in), .cnt_val(cnt_val), .lfsr_en(lfsr_en),
    .cnt_load(cnt_load), .cnt_d(cnt_d), .cnt_en(cnt_en), .led_go(led_go),
    .busy(busy), .result(result), .result_valid(result_valid),
    .early(early), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Behavioural down counter standing in for the external preset counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        cnt_q <= '0;
    else if (cnt_load) cnt_q <= cnt_d;
    else if (cnt_en)   cnt_q <= cnt_q - 12'd1;
  end
  assign cnt_val = use_model ? cnt_q : cnt_force;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cyc();
      tick = 1'b0; cyc();
    end
  endtask

  initial begin
    repeat (2) cyc();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_led_go", 32'(led_go), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_early", 32'(early), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_lfsr_en", 32'(lfsr_en), 1);
    reset = 1'b1;
    cyc();

    // clamp, counter gating, start ignored in GO, same-cycle tick on react
    rand_in = 12'h0AA; cnt_force = 12'd5;
    start = 1'b1; cyc(); start = 1'b0;
    chk("arm_load", 32'(cnt_load), 1);
    chk("arm_clamp", 32'(cnt_d), 500);
    chk("arm_busy", 32'(busy), 1);
    chk("arm_lfsr_off", 32'(lfsr_en), 0);
    rand_in = 12'hAAA; #1;
    chk("arm_noclamp", 32'(cnt_d), 2730);
    cyc();
    chk("wait_load", 32'(cnt_load), 0);
    chk("wait_cnt_d", 32'(cnt_d), 0);
    chk("wait_busy", 32'(busy), 1);
    tick = 1'b1; #1;
    chk("wait_cnt_en", 32'(cnt_en), 1);
    cnt_force = 12'd0; #1;
    chk("wait_cnt_en_zero", 32'(cnt_en), 0);
    tick = 1'b0;
    cyc();
    chk("go_entered", 32'(led_go), 1);
    start = 1'b1; cyc(); start = 1'b0;
    chk("go_start_ign_led", 32'(led_go), 1);
    chk("go_start_ign_load", 32'(cnt_load), 0);
    tick = 1'b1; react = 1'b1; cyc(); tick = 1'b0; react = 1'b0;
    chk("react0_result", 32'(result), 0);
    chk("react0_valid", 32'(result_valid), 1);
    chk("react0_led", 32'(led_go), 0);
    chk("react0_lfsr", 32'(lfsr_en), 1);

    // 600-tick pre-delay, 137 ms reaction, re-arm from DONE
    rand_in = 12'h258; use_model = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    chk("t3_cnt_d", 32'(cnt_d), 600);
    chk("t3_valid_arm", 32'(result_valid), 1);
    cyc();
    chk("t3_valid_clr", 32'(result_valid), 0);
    ticks(599);
    chk("t3_not_go", 32'(led_go), 0);
    ticks(1);
    chk("t3_go", 32'(led_go), 1);
    ticks(137);
    chk("t3_go_held", 32'(led_go), 1);
    react = 1'b1; cyc(); react = 1'b0;
    chk("t3_result", 32'(result), 137);
    chk("t3_valid", 32'(result_valid), 1);
    chk("t3_led_fall", 32'(led_go), 0);
    chk("t3_timeout", 32'(timeout), 0);

    // early press, same cycle as counter zero
    use_model = 1'b0; cnt_force = 12'd0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    react = 1'b1; cyc(); react = 1'b0;
    chk("t4_early", 32'(early), 1);
    chk("t4_led", 32'(led_go), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_valid", 32'(result_valid), 0);
    cyc();
    chk("t4_never_go", 32'(led_go), 0);
    chk("t4_early_hold", 32'(early), 1);

    // timeout at 999 ms
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    chk("t5_early_clr", 32'(early), 0);
    cyc();
    chk("t5_go", 32'(led_go), 1);
    ticks(998);
    chk("t5_go_998", 32'(led_go), 1);
    chk("t5_no_tmo", 32'(timeout), 0);
    ticks(1);
    chk("t5_led", 32'(led_go), 0);
    chk("t5_timeout", 32'(timeout), 1);
    chk("t5_result", 32'(result), 999);
    chk("t5_valid", 32'(result_valid), 0);

    // asynchronous reset in GO, then start+react together
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    chk("t1_go", 32'(led_go), 1);
    ticks(5);
    #2 reset = 1'b0; #1;
    chk("t1_led", 32'(led_go), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_result", 32'(result), 0);
    chk("t1_timeout", 32'(timeout), 0);
    chk("t1_valid", 32'(result_valid), 0);
    chk("t1_early", 32'(early), 0);
    cyc();
    reset = 1'b1;
    cyc();
    start = 1'b1; react = 1'b1; cyc(); start = 1'b0; react = 1'b0;
    chk("sr_load", 32'(cnt_load), 1);
    chk("sr_busy", 32'(busy), 1);
    cyc();
    chk("sr_wait_early", 32'(early), 0);
    chk("sr_wait_busy", 32'(busy), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
